clock_period_meter: RTL and testbench
=====================================

# clock_period_meter

Measures the period of a slow, asynchronous periodic signal, such as a divided clock from the ripple clock divider, in cycles of the fast system clock. It returns each measured period over a valid/ready interface. It is the receiving end of the clock-divider path: it lets fast-domain logic check the division ratio, and detect a stalled or mis-divided clock, without clocking any logic on the divided clock.

## Interface
Parameters:
- SYNC_STAGES, default 2: synchronizer flops on sig_in; legal range ≥ 2.
- COUNT_WIDTH, default 16: width of the period counter and result; legal range ≥ 2.

Ports:
- clk  input  1  system clock; every flop in the block is on posedge clk.
- rst  input  1  synchronous, active-low reset.
- enable  input  1  measurement enable.
- sig_in  input  1  asynchronous signal to measure.
- period_out  output  COUNT_WIDTH  last captured period, in clk cycles.
- period_valid  output  1  period_out holds an unconsumed result.
- period_ready  input  1  consumer accepts the result.
- overflow  output  1  qualifies period_out: the period saturated.
- overrun  output  1  sticky flag: a result was dropped.

## Operation
- sig_in passes through a SYNC_STAGES flop chain, giving s. A register s_prev holds the previous s. A detected edge is edge = s & ~s_prev.
- The sync chain and s_prev reset to 1. A level-high sig_in at reset therefore never produces a false edge.
- State machine, 2 states:
  - IDLE: cnt = 0. On edge with enable = 1: cnt ← 1, go to MEASURE. Edges while enable = 0 are ignored.
  - MEASURE: each cycle without an edge, cnt ← cnt + 1, saturating at 2^COUNT_WIDTH − 1. On edge: capture cnt as the result, then cnt ← 1 and stay in MEASURE.
  - enable = 0 in either state: go to IDLE on the next clk, cnt ← 0, overrun ← 0. A pending result is retained until accepted.
- Capture, in the same cycle as the edge:
  - If period_valid = 0, or period_ready = 1 in that cycle: period_out ← cnt, overflow ← (cnt == all-ones), period_valid ← 1.
  - Otherwise the new result is dropped, overrun ← 1, and period_out, period_valid and overflow are unchanged.
- Handshake: period_valid stays high until the cycle with period_valid & period_ready. period_valid then falls, unless a capture happens in that same cycle; in that case valid stays 1 with the new data.
- period_out and overflow are stable while period_valid = 1.
- The result counts clk cycles between consecutive detected rising edges. A result of N means N clk periods. The minimum meaningful result is 2.
- Input requirement: each phase of sig_in must last at least 2 clk cycles for exact results. Shorter phases may be missed; this is accepted behaviour, not an error.

## Timing
- Reset values (rst = 0 at a posedge): state IDLE, cnt 0, period_out 0, period_valid 0, overflow 0, overrun 0, sync chain and s_prev 1.
- Reset mid-measurement discards the partial count and any pending result.
- Latency: a sig_in rise first sampled at clk edge n gives edge = 1 in cycle n + SYNC_STAGES. The capture takes effect at the following posedge, so period_valid is high in cycle n + SYNC_STAGES + 1.
- Synchronizer latency is constant, so it cancels in the period. Sampling jitter is ±1 cycle for asynchronous sig_in and 0 for a sig_in that is synchronous to clk.
- The first result appears after the second detected edge following entry to MEASURE.
- Saturation: with no edge, cnt holds at all-ones. The next edge captures all-ones with overflow = 1, and then measurement resumes normally.
- Simultaneous enable fall and edge: enable wins, so there is no capture.

## Test plan
- sig_in is the 7-stage divider output, i.e. a 128-cycle period synchronous to clk. With enable = 1 and period_ready = 1: the first result arrives after 2 edges, then every result is period_out = 128 with overflow = 0.
- Same stimulus with period_ready held low for 300 cycles: period_out stays 128 and valid stays 1, and overrun = 1 after the second subsequent edge. Pulsing period_ready gives valid = 0 until the next capture.
- COUNT_WIDTH = 4, sig_in period 40: period_out = 15 with overflow = 1. Switching to period 10 then gives period_out = 10 with overflow = 0.
- sig_in held high through reset, then toggled with period 20: no result before the second real rising edge, and the first result is exactly 20.
- rst pulsed low mid-MEASURE while a result is pending: the next cycle shows period_valid = 0, period_out = 0 and overrun = 0, and the measurement restarts cleanly.
- Capture coincident with an accepting period_ready: valid stays 1 and period_out updates in the same cycle. Separately, enable falls in the same cycle as an edge: no new result appears.

Source files
------------

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures the period of a slow asynchronous signal in cycles of clk.
// The input is synchronised, rising edges are detected, and the clk cycles between
// consecutive edges are returned over a valid/ready interface with overflow/overrun flags.
module clock_period_meter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] period_out,
  output logic                   period_valid,
  input  logic                   period_ready,
  output logic                   overflow,
  output logic                   overrun
);

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  localparam logic [COUNT_WIDTH-1:0] CntMax = '1;
  localparam logic [COUNT_WIDTH-1:0] CntOne = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev_q;
  logic                   sig_s;
  logic                   edge_det;

  state_e                 state_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] cnt_inc;
  logic [COUNT_WIDTH-1:0] period_q;
  logic                   valid_q;
  logic                   overflow_q;
  logic                   overrun_q;
  logic                   accept;
  logic                   capture_ok;

  assign sig_s    = sync_q[SYNC_STAGES-1];
  assign edge_det = sig_s & ~s_prev_q;

  // Synchroniser and edge history; reset to 1 so a high input at reset is not an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q   <= '1;
      s_prev_q <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_prev_q <= sig_s;
    end
  end

  // Saturating increment and handshake qualifiers.
  always_comb begin
    cnt_inc    = (cnt_q == CntMax) ? CntMax : cnt_q + CntOne;
    accept     = valid_q & period_ready;
    capture_ok = ~valid_q | period_ready;
  end

  // Measurement FSM with registered result, valid, overflow and overrun.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      // Consumption first; a capture later in this block re-asserts valid.
      if (accept) begin
        valid_q <= 1'b0;
      end
      if (!enable) begin
        // Disable wins over a coincident edge; a pending result is kept.
        state_q   <= StIdle;
        cnt_q     <= '0;
        overrun_q <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (edge_det) begin
              cnt_q   <= CntOne;
              state_q <= StMeasure;
            end
          end
          StMeasure: begin
            if (edge_det) begin
              cnt_q <= CntOne;
              if (capture_ok) begin
                period_q   <= cnt_q;
                overflow_q <= (cnt_q == CntMax);
                valid_q    <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign overflow     = overflow_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: a default-width instance (a) and a 4-bit
// instance (b) share clk, rst and a bench-generated sig_in synchronous to clk.
module tb_clock_period_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sig_in;
  logic        en_a, rdy_a, val_a, ovf_a, ovr_a;
  logic [15:0] out_a;
  logic        en_b, rdy_b, val_b, ovf_b, ovr_b;
  logic [3:0]  out_b;

  int total = 0;
  int bad   = 0;

  // sig_in generator state: toggles every gen_half cycles while gen_on.
  int gen_half = 10;
  int gen_cnt  = 0;
  bit gen_on   = 1'b0;
  int rises    = 0;

  clock_period_meter #(.SYNC_STAGES(2), .COUNT_WIDTH(16)) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .enable       (en_a),
    .sig_in       (sig_in),
    .period_out   (out_a),
    .period_valid (val_a),
    .period_ready (rdy_a),
    .overflow     (ovf_a),
    .overrun      (ovr_a)
  );

  clock_period_meter #(.SYNC_STAGES(2), .COUNT_WIDTH(4)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .enable       (en_b),
    .sig_in       (sig_in),
    .period_out   (out_b),
    .period_valid (val_b),
    .period_ready (rdy_b),
    .overflow     (ovf_b),
    .overrun      (ovr_b)
  );

  // One clock: outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (gen_on) begin
      if (gen_cnt >= gen_half - 1) begin
        sig_in  = ~sig_in;
        gen_cnt = 0;
        if (sig_in) rises++;
      end else begin
        gen_cnt++;
      end
    end
  endtask

  task automatic wait_valid(input bit sel_b, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if ((sel_b ? val_b : val_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en_a = 1'b0; en_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    sig_in = 1'b1; gen_on = 1'b0;
    repeat (3) tick();
    total++; if (val_a !== 1'b0) begin bad++; $display("FAIL reset_valid_a: got %0b want 0", val_a); end
    total++; if (out_a !== 16'd0) begin bad++; $display("FAIL reset_out_a: got %0d want 0", out_a); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_ovf_a: got %0b want 0", ovf_a); end
    total++; if (ovr_a !== 1'b0) begin bad++; $display("FAIL reset_ovr_a: got %0b want 0", ovr_a); end
    total++; if (val_b !== 1'b0) begin bad++; $display("FAIL reset_valid_b: got %0b want 0", val_b); end
    total++; if (out_b !== 4'd0) begin bad++; $display("FAIL reset_out_b: got %0d want 0", out_b); end
  endtask

  task automatic test_high_through_reset();
    bit ok;
    sig_in = 1'b1; rst = 1'b0; en_a = 1'b1; rdy_a = 1'b1;
    repeat (4) tick();
    rst = 1'b1; gen_half = 10; gen_cnt = 0; rises = 0; gen_on = 1'b1;
    wait_valid(1'b0, 100, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL hr_timeout: got %0b want 1", ok); end
    total++; if (rises !== 2) begin bad++; $display("FAIL hr_rises: got %0d want 2", rises); end
    total++; if (out_a !== 16'd20) begin bad++; $display("FAIL hr_period: got %0d want 20", out_a); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL hr_ovf: got %0b want 0", ovf_a); end
  endtask

  task automatic test_period_128();
    bit ok;
    int nres;
    en_a = 1'b0; gen_on = 1'b0; sig_in = 1'b0;
    repeat (5) tick();
    gen_half = 64; gen_cnt = 0; rises = 0; en_a = 1'b1; gen_on = 1'b1;
    wait_valid(1'b0, 300, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL p128_timeout: got %0b want 1", ok); end
    total++; if (rises !== 2) begin bad++; $display("FAIL p128_first_rises: got %0d want 2", rises); end
    total++; if (out_a !== 16'd128) begin bad++; $display("FAIL p128_first: got %0d want 128", out_a); end
    nres = 0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (val_a === 1'b1) begin
        nres++;
        total++;
        if (out_a !== 16'd128 || ovf_a !== 1'b0) begin
          bad++;
          $display("FAIL p128_result: got %0d/%0b want 128/0", out_a, ovf_a);
        end
      end
    end
    total++; if (nres !== 5) begin bad++; $display("FAIL p128_count: got %0d want 5", nres); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit hold_bad;
    rdy_a = 1'b0;
    wait_valid(1'b0, 200, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_timeout: got %0b want 1", ok); end
    total++; if (ovr_a !== 1'b0) begin bad++; $display("FAIL bp_ovr_early: got %0b want 0", ovr_a); end
    hold_bad = 1'b0;
    repeat (300) begin
      tick();
      if (val_a !== 1'b1 || out_a !== 16'd128) hold_bad = 1'b1;
    end
    total++; if (hold_bad !== 1'b0) begin bad++; $display("FAIL bp_hold: got %0b want 0", hold_bad); end
    total++; if (ovr_a !== 1'b1) begin bad++; $display("FAIL bp_overrun: got %0b want 1", ovr_a); end
    rdy_a = 1'b1;
    tick();
    rdy_a = 1'b0;
    total++; if (val_a !== 1'b0) begin bad++; $display("FAIL bp_pulse: got %0b want 0", val_a); end
    wait_valid(1'b0, 200, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_recapture: got %0b want 1", ok); end
    total++; if (out_a !== 16'd128) begin bad++; $display("FAIL bp_value: got %0d want 128", out_a); end
  endtask

  task automatic test_coincident();
    bit ok;
    rdy_a = 1'b1;
    tick();
    rdy_a = 1'b0;
    wait_valid(1'b0, 200, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL co_timeout: got %0b want 1", ok); end
    // Three cycles past the rise: stretching the phases lands the next rise 100 later.
    gen_half = 50;
    repeat (99) tick();
    rdy_a = 1'b1;
    tick();
    total++; if (val_a !== 1'b1) begin bad++; $display("FAIL co_valid: got %0b want 1", val_a); end
    total++; if (out_a !== 16'd100) begin bad++; $display("FAIL co_update: got %0d want 100", out_a); end
    tick();
    total++; if (val_a !== 1'b0) begin bad++; $display("FAIL co_drain: got %0b want 0", val_a); end
  endtask

  task automatic test_enable_edge();
    repeat (98) tick();
    en_a = 1'b0;
    tick();
    total++; if (val_a !== 1'b0) begin bad++; $display("FAIL en_edge_valid: got %0b want 0", val_a); end
    repeat (3) tick();
    total++; if (val_a !== 1'b0) begin bad++; $display("FAIL en_edge_later: got %0b want 0", val_a); end
    total++; if (ovr_a !== 1'b0) begin bad++; $display("FAIL en_edge_ovr: got %0b want 0", ovr_a); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    en_a = 1'b1; rdy_a = 1'b0; gen_half = 10;
    wait_valid(1'b0, 200, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rm_timeout: got %0b want 1", ok); end
    repeat (45) tick();
    total++; if (ovr_a !== 1'b1) begin bad++; $display("FAIL rm_pre_ovr: got %0b want 1", ovr_a); end
    rst = 1'b0;
    tick();
    total++; if (val_a !== 1'b0) begin bad++; $display("FAIL rm_valid: got %0b want 0", val_a); end
    total++; if (out_a !== 16'd0) begin bad++; $display("FAIL rm_out: got %0d want 0", out_a); end
    total++; if (ovr_a !== 1'b0) begin bad++; $display("FAIL rm_ovr: got %0b want 0", ovr_a); end
    rst = 1'b1; rdy_a = 1'b1;
    wait_valid(1'b0, 100, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rm_restart: got %0b want 1", ok); end
    total++; if (out_a !== 16'd20) begin bad++; $display("FAIL rm_period: got %0d want 20", out_a); end
  endtask

  task automatic test_saturation();
    bit ok;
    en_a = 1'b0; en_b = 1'b1; rdy_b = 1'b1; gen_half = 20;
    for (int k = 0; k < 2; k++) begin
      wait_valid(1'b1, 300, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL sat_timeout: got %0b want 1", ok); end
      total++; if (out_b !== 4'd15) begin bad++; $display("FAIL sat_value: got %0d want 15", out_b); end
      total++; if (ovf_b !== 1'b1) begin bad++; $display("FAIL sat_ovf: got %0b want 1", ovf_b); end
    end
    gen_half = 5;
    for (int k = 0; k < 2; k++) begin
      wait_valid(1'b1, 50, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL p10_timeout: got %0b want 1", ok); end
      total++; if (out_b !== 4'd10) begin bad++; $display("FAIL p10_value: got %0d want 10", out_b); end
      total++; if (ovf_b !== 1'b0) begin bad++; $display("FAIL p10_ovf: got %0b want 0", ovf_b); end
    end
  endtask

  initial begin
    test_reset();
    test_high_through_reset();
    test_period_128();
    test_backpressure();
    test_coincident();
    test_enable_edge();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
